// File: rtl/rv32_types.sv
// rtl/rv32_types.sv - shared RV32 memory bus types and arbiter state encoding
//
// Purpose: request/response bus structs used by the fetch stage, the memory
// stage and the downstream memory, plus the memory arbiter state type.
// Ports: none (package).

package rv32_types;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_t;

    typedef struct packed {
        logic [31:0] addr;
        mem_op_t     op;
        logic [31:0] data;
    } memory_request_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] data;
    } memory_response_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rv32_mem_arbiter.sv
// rtl/rv32_mem_arbiter.sv - two-requester (fetch/memory stage) single-port memory arbiter
//
// Purpose: grants one downstream memory access at a time to either the
// instruction fetch or the data (memory stage) requester. Data wins ties,
// but after STREAK_MAX consecutive data grants with an instruction waiting,
// the instruction request is served. The owner's request is captured at
// grant and held until the memory completes.
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   instr_req_valid     fetch request valid
//   instr_request       fetch request (addr/op/data)
//   instr_abort         fetch redirect: drop the in-flight fetch response
//   instr_response      ready/data back to fetch
//   data_req_valid      memory-stage request valid
//   data_request        memory-stage request
//   data_response       ready/data back to memory stage
//   mem_req_valid       downstream request valid (INSTR or DATA state)
//   mem_request         captured request of the current owner
//   mem_response        downstream completion and read data

module rv32_mem_arbiter
    import rv32_types::*;
#(
    parameter int STREAK_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_req_valid,
    input  memory_request_t  instr_request,
    input  logic             instr_abort,
    output memory_response_t instr_response,
    input  logic             data_req_valid,
    input  memory_request_t  data_request,
    output memory_response_t data_response,
    output logic             mem_req_valid,
    output memory_request_t  mem_request,
    input  memory_response_t mem_response
);

    localparam int STREAK_W = $clog2(STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(STREAK_MAX);

    arb_state_t            state, state_next;
    logic [STREAK_W-1:0]   streak, streak_next;
    logic                  abort_flag, abort_next;
    memory_request_t       captured, captured_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            streak     <= '0;
            abort_flag <= 1'b0;
            captured   <= '0;
        end else begin
            state      <= state_next;
            streak     <= streak_next;
            abort_flag <= abort_next;
            captured   <= captured_next;
        end
    end

    always_comb begin
        state_next     = state;
        streak_next    = streak;
        abort_next     = abort_flag;
        captured_next  = captured;
        instr_response = '0;
        data_response  = '0;

        case (state)
            IDLE: begin
                abort_next = 1'b0;
                if (data_req_valid && (!instr_req_valid || streak < STREAK_LIMIT)) begin
                    state_next    = DATA;
                    captured_next = data_request;
                    // Streak only counts data grants that made a fetch wait;
                    // the guard above keeps it at or below the limit.
                    streak_next   = instr_req_valid ? streak + 1'b1 : '0;
                end else if (instr_req_valid) begin
                    state_next    = INSTR;
                    captured_next = instr_request;
                    streak_next   = '0;
                end
            end
            INSTR: begin
                if (mem_response.ready) begin
                    state_next = IDLE;
                    abort_next = 1'b0;
                    // An abort seen earlier or arriving in this very cycle
                    // drops the response; the memory access still completes.
                    if (!(abort_flag || instr_abort) && !reset) begin
                        instr_response = '{ready: 1'b1, data: mem_response.data};
                    end
                end else begin
                    abort_next = abort_flag || instr_abort;
                end
            end
            DATA: begin
                if (mem_response.ready) begin
                    state_next = IDLE;
                    if (!reset) begin
                        data_response = '{ready: 1'b1, data: mem_response.data};
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_req_valid = !reset && (state != IDLE);
    assign mem_request   = captured;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb/tb_rv32_mem_arbiter.sv - self-checking bench for rv32_mem_arbiter

module tb_rv32_mem_arbiter;
    import rv32_types::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             instr_req_valid;
    memory_request_t  instr_request;
    logic             instr_abort;
    memory_response_t instr_response;
    logic             data_req_valid;
    memory_request_t  data_request;
    memory_response_t data_response;
    logic             mem_req_valid;
    memory_request_t  mem_request;
    memory_response_t mem_response;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32_mem_arbiter #(.STREAK_MAX(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_req_valid (instr_req_valid),
        .instr_request   (instr_request),
        .instr_abort     (instr_abort),
        .instr_response  (instr_response),
        .data_req_valid  (data_req_valid),
        .data_request    (data_request),
        .data_response   (data_response),
        .mem_req_valid   (mem_req_valid),
        .mem_request     (mem_request),
        .mem_response    (mem_response)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] ia;
        logic        ab;
        logic        dv;
        logic [31:0] da;
        logic        mr;
        logic [31:0] md;
        logic        e_mv;
        logic [31:0] e_ma;
        logic        e_ir;
        logic [31:0] e_id;
        logic        e_dr;
        logic [31:0] e_dd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic iv, input logic [31:0] ia,
                                input logic ab, input logic dv, input logic [31:0] da,
                                input logic mr, input logic [31:0] md,
                                input logic e_mv, input logic [31:0] e_ma,
                                input logic e_ir, input logic [31:0] e_id,
                                input logic e_dr, input logic [31:0] e_dd);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ia = ia; v.ab = ab; v.dv = dv; v.da = da;
        v.mr = mr; v.md = md; v.e_mv = e_mv; v.e_ma = e_ma;
        v.e_ir = e_ir; v.e_id = e_id; v.e_dr = e_dr; v.e_dd = e_dd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [31:0] ia,
                         input logic ab, input logic dv, input logic [31:0] da,
                         input logic mr, input logic [31:0] md);
        reset           = rst;
        instr_req_valid = iv;
        instr_request   = '{addr: ia, op: MEM_READ, data: 32'h0};
        instr_abort     = ab;
        data_req_valid  = dv;
        data_request    = '{addr: da, op: MEM_WRITE, data: da ^ 32'h5A5A_0000};
        mem_response    = '{ready: mr, data: md};
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        string exp_order;
        string nm;
        logic  saw_ready;

        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // rst iv ia ab dv da mr md | mv ma ir id dr dd
        vecs.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,   1, 32'hDEAD,  0, 32'h0,   0, 32'h0,  0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h100, 0, 0, 32'h0,   1, 32'h55,    0, 32'h0,   0, 32'h0,  0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h100, 0, 0, 32'h0,   0, 32'h0,     1, 32'h100, 0, 32'h0,  0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h104, 0, 0, 32'h0,   0, 32'h0,     1, 32'h100, 0, 32'h0,  0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h100, 0, 0, 32'h0,   1, 32'h13,    1, 32'h100, 1, 32'h13, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h77,    0, 32'h100, 0, 32'h0,  0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1, 32'h200, 0, 32'h0,     0, 32'h100, 0, 32'h0,  0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1, 32'h300, 0, 32'h0,     1, 32'h200, 0, 32'h0,  0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 1, 32'h300, 0, 32'h0,     1, 32'h200, 0, 32'h0,  0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h300, 1, 32'hABCD,  1, 32'h200, 0, 32'h0,  1, 32'hABCD));
        vecs.push_back(mk(0, 0, 32'h0,   1, 0, 32'h0,   0, 32'h0,     0, 32'h200, 0, 32'h0,  0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h400, 0, 0, 32'h0,   0, 32'h0,     0, 32'h200, 0, 32'h0,  0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h11,    1, 32'h400, 1, 32'h11, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,     0, 32'h400, 0, 32'h0,  0, 32'h0));

        next_cycle();
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].ia, vecs[i].ab,
                  vecs[i].dv, vecs[i].da, vecs[i].mr, vecs[i].md);
            to_sample();
            chk($sformatf("vec%0d_mem_req_valid", i), 32'(mem_req_valid), 32'(vecs[i].e_mv));
            chk($sformatf("vec%0d_mem_addr", i), mem_request.addr, vecs[i].e_ma);
            chk($sformatf("vec%0d_instr_ready", i), 32'(instr_response.ready), 32'(vecs[i].e_ir));
            chk($sformatf("vec%0d_instr_data", i), instr_response.data, vecs[i].e_id);
            chk($sformatf("vec%0d_data_ready", i), 32'(data_response.ready), 32'(vecs[i].e_dr));
            chk($sformatf("vec%0d_data_data", i), data_response.data, vecs[i].e_dd);
            if (i == 7) chk("data_op_captured", 32'(mem_request.op), 32'(MEM_WRITE));
            next_cycle();
        end

        // Fairness: both requesters valid continuously, single-cycle memory.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        exp_order = "DDDDIDDDDI";
        for (int g = 0; g < 10; g++) begin
            drive(1'b0, 1'b1, 32'h1000, 1'b0, 1'b1, 32'h2000, 1'b1, 32'h100 + g);
            to_sample();
            chk($sformatf("grant%0d_idle_gap", g), 32'(mem_req_valid), 32'd0);
            next_cycle();
            to_sample();
            chk($sformatf("grant%0d_valid", g), 32'(mem_req_valid), 32'd1);
            if (exp_order[g] == "D") begin
                chk($sformatf("grant%0d_addr", g), mem_request.addr, 32'h2000);
                chk($sformatf("grant%0d_data_ready", g), 32'(data_response.ready), 32'd1);
                chk($sformatf("grant%0d_instr_ready", g), 32'(instr_response.ready), 32'd0);
            end else begin
                chk($sformatf("grant%0d_addr", g), mem_request.addr, 32'h1000);
                chk($sformatf("grant%0d_instr_ready", g), 32'(instr_response.ready), 32'd1);
                chk($sformatf("grant%0d_data_ready", g), 32'(data_response.ready), 32'd0);
            end
            next_cycle();
        end

        // Abort pulsed mid-INSTR, completion three cycles later.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        saw_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, 32'h0, (c == 0), 1'b0, 32'h0, (c == 3), 32'h99);
            to_sample();
            if (instr_response.ready) saw_ready = 1'b1;
            chk($sformatf("abort_mid_valid%0d", c), 32'(mem_req_valid), 32'd1);
            next_cycle();
        end
        chk("abort_mid_no_ready", 32'(saw_ready), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        to_sample();
        chk("abort_mid_back_idle", 32'(mem_req_valid), 32'd0);
        next_cycle();

        // Abort in the completion cycle, then a normal fetch.
        drive(1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h66);
        to_sample();
        chk("abort_same_cycle_ready", 32'(instr_response.ready), 32'd0);
        next_cycle();
        drive(1'b0, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        to_sample();
        chk("abort_same_cycle_idle", 32'(mem_req_valid), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h42);
        to_sample();
        chk("after_abort_addr", mem_request.addr, 32'h700);
        chk("after_abort_ready", 32'(instr_response.ready), 32'd1);
        chk("after_abort_data", instr_response.data, 32'h42);
        next_cycle();

        // Reset during a DATA wait drops the transaction.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h800, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h800, 1'b0, 32'h0);
        to_sample();
        chk("rst_mid_pre_valid", 32'(mem_req_valid), 32'd1);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5);
        to_sample();
        chk("rst_mid_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mid_data_ready", 32'(data_response.ready), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h6);
        to_sample();
        chk("rst_after_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_after_data_ready", 32'(data_response.ready), 32'd0);
        chk("rst_after_addr", mem_request.addr, 32'h0);
        next_cycle();

        nm = "done";
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_mem_arbiter.md
RV32_MEM_ARBITER -- requirements
Module: rv32_mem_arbiter

Interface
REQ-001 Parameter: STREAK_MAX, default 4, max consecutive data grants while an instruction request waits.
REQ-002 clk  input  1  core clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr_req_valid  input  1  fetch stage requests a memory access.
REQ-005 instr_request  input  memory_request_t  fetch request: addr, op, data.
REQ-006 instr_abort  input  1  fetch redirect; discard the in-flight instruction response.
REQ-007 instr_response  output  memory_response_t  ready/data returned to fetch.
REQ-008 data_req_valid  input  1  memory stage requests a memory access.
REQ-009 data_request  input  memory_request_t  memory-stage request.
REQ-010 data_response  output  memory_response_t  ready/data returned to memory stage.
REQ-011 mem_req_valid  output  1  downstream request valid.
REQ-012 mem_request  output  memory_request_t  captured request of the current owner.
REQ-013 mem_response  input  memory_response_t  downstream completion (ready) and read data.

Function
REQ-014 FSM states: IDLE, INSTR, DATA; mem_req_valid SHALL be 1 exactly in INSTR and DATA.
REQ-015 IDLE, data_req_valid=1 and (instr_req_valid=0 or streak<STREAK_MAX) -> DATA; capture data_request; streak += 1 if instr_req_valid else streak = 0.
REQ-016 IDLE, otherwise instr_req_valid=1 -> INSTR; capture instr_request; streak = 0.
REQ-017 Both valid in IDLE: data wins unless streak == STREAK_MAX, then instruction wins.
REQ-018 streak width $clog2(STREAK_MAX+1); saturates at STREAK_MAX, never wraps.
REQ-019 mem_request SHALL be the captured register; requester input changes after capture are ignored.
REQ-020 INSTR/DATA with mem_response.ready=0: hold state and mem_request unchanged.
REQ-021 INSTR/DATA with mem_response.ready=1: owner response = {ready=1, data=mem_response.data} combinationally in the same cycle; next state IDLE.
REQ-022 The non-owner response SHALL always be {ready=0, data=0}; in IDLE both responses are {0,0}.
REQ-023 Latency: valid at cycle T -> mem_req_valid at T+1; single-cycle memory -> owner ready at T+1; one IDLE cycle between consecutive grants.
REQ-024 Requesters SHALL hold valid until their response ready; a valid dropped before ready still completes and its response is delivered.
REQ-025 instr_abort in INSTR sets abort flag; on completion instr_response.ready forced 0; flag clears on return to IDLE.
REQ-026 instr_abort in the completion cycle itself also suppresses instr_response.ready.
REQ-027 instr_abort in IDLE or DATA has no effect.
REQ-028 mem_response.ready in IDLE SHALL be ignored.

Reset
REQ-029 reset=1: next state IDLE, streak=0, abort flag=0, captured request all-zero.
REQ-030 While reset=1: mem_req_valid=0, both responses {0,0}, including any mem_response.ready that cycle.
REQ-031 Reset mid-transaction drops it; no response is delivered for it after reset.

Structure
REQ-032 arb_state_t (IDLE/INSTR/DATA) SHALL live in the shared rv32_types package next to memory_request_t and memory_response_t.
REQ-033 memory_request_t/memory_response_t SHALL be reused unchanged; no new bus types.
REQ-034 Single flat module; no sub-module.

Verification
REQ-035 Instr-only, addr 0x100, memory ready after 2 cycles with data 0x00000013 -> instr_response ready=1 with 0x00000013 once; data_response stays {0,0}.
REQ-036 Both valid continuously, STREAK_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-037 instr_abort pulsed mid-INSTR, ready 3 cycles later -> instr_response.ready never 1; FSM returns to IDLE.
REQ-038 instr_abort in the same cycle as mem_response.ready -> ready suppressed; next instr request served normally.
REQ-039 reset asserted during DATA wait -> mem_req_valid=0 next cycle; later mem_response.ready produces no data_response.
REQ-040 data_request.addr changed during DATA wait (0x200 -> 0x300) -> mem_request.addr stays 0x200 until completion.
